// File: rtl/piece_rng.sv
// piece_rng: free-running Fibonacci XNOR LFSR with seed load, plus a
// request/valid draw engine that rejection-samples a uniform piece index
// in 0..NUM_PIECES-1 with a bounded retry count and a lowest-index fallback.
// Optional bag mode (macro PIECE_RNG_BAG_EN) makes every run of NUM_PIECES
// consecutive draws a permutation of 0..NUM_PIECES-1.
module piece_rng #(
  parameter int unsigned LFSR_W     = 10,
  parameter int unsigned NUM_PIECES = 7,
  parameter int unsigned PIECE_W    = 3,
  parameter int unsigned MAX_TRIES  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  input  logic               req,
  output logic               busy,
  output logic               piece_valid,
  output logic [PIECE_W-1:0] piece
);

  localparam int unsigned TRIES_W = 8;
  localparam int unsigned CMP_W   = PIECE_W + 1;
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);
  localparam logic [CMP_W-1:0]   NUM_P    = CMP_W'(NUM_PIECES);

  // XNOR tap positions per width; tap n maps to ps bit n-1
  function automatic logic [15:0] tap_mask(input int unsigned w);
    case (w)
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]       TAPS_ALL = tap_mask(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];

  typedef enum logic {IDLE, DRAW} state_e;

  logic [LFSR_W-1:0]  ps_q, ps_d;
  logic               fb;
  state_e             state_q, state_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [PIECE_W-1:0] piece_q, piece_d;
  logic               piece_valid_q, piece_valid_d;
  logic               busy_q, busy_d;
  logic [PIECE_W-1:0] cand;
  logic               cand_ok;
  logic [PIECE_W-1:0] fallback;

`ifdef PIECE_RNG_BAG_EN
  logic [NUM_PIECES-1:0] mask_q, mask_d;
  logic                  cand_used;
`endif

  assign busy        = busy_q;
  assign piece_valid = piece_valid_q;
  assign piece       = piece_q;

  // LFSR next value; a load beats stepping and the XNOR lock-up seed maps to 0
  always_comb begin
    fb = ~^(ps_q & TAPS);
    if (seed_load) begin
      ps_d = (&seed) ? '0 : seed;
    end else begin
      ps_d = {ps_q[LFSR_W-2:0], fb};
    end
  end

`ifdef PIECE_RNG_BAG_EN
  // Candidate is accepted only if in range and not yet drawn from this bag
  always_comb begin
    cand      = ps_q[PIECE_W-1:0];
    cand_used = 1'b0;
    fallback  = '0;
    for (int i = 0; i < int'(NUM_PIECES); i++) begin
      if (mask_q[i] && (cand == PIECE_W'(i))) cand_used = 1'b1;
    end
    for (int i = int'(NUM_PIECES) - 1; i >= 0; i--) begin
      if (!mask_q[i]) fallback = PIECE_W'(i);
    end
    cand_ok = ({1'b0, cand} < NUM_P) && !cand_used;
  end

  // Mark the drawn piece; a full bag starts over on the same edge
  always_comb begin
    mask_d = mask_q;
    if (piece_valid_d) begin
      for (int i = 0; i < int'(NUM_PIECES); i++) begin
        if (piece_d == PIECE_W'(i)) mask_d[i] = 1'b1;
      end
      if (&mask_d) mask_d = '0;
    end
  end

  // Bag mask register; untouched by seed loads
  always_ff @(posedge clk) begin
    if (reset) mask_q <= '0;
    else       mask_q <= mask_d;
  end
`else
  // Candidate is accepted only if in range; fallback is always index 0
  always_comb begin
    cand     = ps_q[PIECE_W-1:0];
    fallback = '0;
    cand_ok  = ({1'b0, cand} < NUM_P);
  end
`endif

  // Draw FSM next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    tries_d       = tries_q;
    piece_d       = piece_q;
    piece_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        if (cand_ok) begin
          piece_d       = cand;
          piece_valid_d = 1'b1;
          state_d       = IDLE;
        end else if (tries_q == LAST_TRY) begin
          piece_d       = fallback;
          piece_valid_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tries_d = tries_q + TRIES_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRAW);
  end

  // State, LFSR and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q          <= '0;
      state_q       <= IDLE;
      tries_q       <= '0;
      piece_q       <= '0;
      piece_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      ps_q          <= ps_d;
      state_q       <= state_d;
      tries_q       <= tries_d;
      piece_q       <= piece_d;
      piece_valid_q <= piece_valid_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_piece_rng.sv
// tb_piece_rng: directed vector table plus multi-cycle sequences for
// piece_rng. Two instances share inputs: default MAX_TRIES=16 and MAX_TRIES=1.
// Define PIECE_RNG_BAG_EN to exercise the bag-mode permutation property.
module tb_piece_rng;

  logic       clk;
  logic       reset;
  logic       seed_load;
  logic [9:0] seed;
  logic       req;
  logic       busy0, pv0, busy1, pv1;
  logic [2:0] piece0, piece1;

  int checks;
  int failures;

  piece_rng dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .req(req),
    .busy(busy0), .piece_valid(pv0), .piece(piece0)
  );

  piece_rng #(.MAX_TRIES(1)) dut1 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .req(req),
    .busy(busy1), .piece_valid(pv1), .piece(piece1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       sl;
    logic [9:0] sd;
    logic       rq;
    logic [9:0] e_ps;
    logic       e_busy;
    logic       e_pv;
    logic [2:0] e_piece;
    logic       e1_busy;
    logic       e1_pv;
    logic [2:0] e1_piece;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic sl, logic [9:0] sd, logic rq,
                              logic [9:0] ps, logic b, logic pv, logic [2:0] pc,
                              logic b1, logic pv1_e, logic [2:0] pc1);
    vec_t v;
    v.rst = rst; v.sl = sl; v.sd = sd; v.rq = rq;
    v.e_ps = ps; v.e_busy = b; v.e_pv = pv; v.e_piece = pc;
    v.e1_busy = b1; v.e1_pv = pv1_e; v.e1_piece = pc1;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifndef PIECE_RNG_BAG_EN
  logic [9:0]  m_ps;
  logic        m_busy [2];
  int unsigned m_tries [2];
  logic        m_pv [2];
  logic [2:0]  m_piece [2];
  int unsigned mt;
  logic [2:0]  mcand;
  int          draws;
  int          last_pv;
`else
  logic [2:0] p0 [14];
  logic [2:0] p1 [14];
  int         n0, n1, cnt;
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1; seed_load = 1'b0; seed = '0; req = 1'b0;

`ifndef PIECE_RNG_BAG_EN
    //           rst sl seed    rq  ps      b  pv pc   b1 pv1 pc1
    vecs[0]  = mk(1, 0, 10'h000, 0, 10'h000, 0, 0, 0,  0, 0, 0);
    vecs[1]  = mk(1, 0, 10'h000, 0, 10'h000, 0, 0, 0,  0, 0, 0);
    vecs[2]  = mk(0, 0, 10'h000, 0, 10'h001, 0, 0, 0,  0, 0, 0);
    vecs[3]  = mk(0, 0, 10'h000, 0, 10'h003, 0, 0, 0,  0, 0, 0);
    vecs[4]  = mk(0, 0, 10'h000, 0, 10'h007, 0, 0, 0,  0, 0, 0);
    vecs[5]  = mk(0, 0, 10'h000, 0, 10'h00F, 0, 0, 0,  0, 0, 0);
    vecs[6]  = mk(0, 0, 10'h000, 0, 10'h01F, 0, 0, 0,  0, 0, 0);
    vecs[7]  = mk(0, 0, 10'h000, 0, 10'h03F, 0, 0, 0,  0, 0, 0);
    vecs[8]  = mk(0, 0, 10'h000, 0, 10'h07F, 0, 0, 0,  0, 0, 0);
    vecs[9]  = mk(0, 0, 10'h000, 0, 10'h0FE, 0, 0, 0,  0, 0, 0);
    vecs[10] = mk(0, 0, 10'h000, 0, 10'h1FC, 0, 0, 0,  0, 0, 0);
    vecs[11] = mk(0, 1, 10'h3FF, 0, 10'h000, 0, 0, 0,  0, 0, 0);
    vecs[12] = mk(0, 1, 10'h155, 0, 10'h155, 0, 0, 0,  0, 0, 0);
    vecs[13] = mk(0, 0, 10'h000, 0, 10'h2AA, 0, 0, 0,  0, 0, 0);
    vecs[14] = mk(0, 1, 10'h07F, 1, 10'h07F, 1, 0, 0,  1, 0, 0);
    vecs[15] = mk(0, 0, 10'h000, 0, 10'h0FE, 1, 0, 0,  0, 1, 0);
    vecs[16] = mk(0, 0, 10'h000, 0, 10'h1FC, 0, 1, 6,  0, 0, 0);
    vecs[17] = mk(0, 0, 10'h000, 0, 10'h3F8, 0, 0, 6,  0, 0, 0);
    vecs[18] = mk(0, 1, 10'h002, 1, 10'h002, 1, 0, 6,  1, 0, 0);
    vecs[19] = mk(0, 0, 10'h000, 0, 10'h005, 0, 1, 2,  0, 1, 2);
    vecs[20] = mk(0, 0, 10'h000, 1, 10'h00B, 1, 0, 2,  1, 0, 2);
    vecs[21] = mk(0, 0, 10'h000, 0, 10'h017, 0, 1, 3,  0, 1, 3);
    vecs[22] = mk(0, 0, 10'h000, 1, 10'h02F, 1, 0, 3,  1, 0, 3);
    vecs[23] = mk(0, 0, 10'h000, 1, 10'h05F, 1, 0, 3,  0, 1, 0);
    vecs[24] = mk(0, 0, 10'h000, 0, 10'h0BE, 1, 0, 3,  0, 0, 0);
    vecs[25] = mk(0, 0, 10'h000, 0, 10'h17D, 0, 1, 6,  0, 0, 0);
    vecs[26] = mk(0, 0, 10'h000, 0, 10'h2FA, 0, 0, 6,  0, 0, 0);
    vecs[27] = mk(0, 0, 10'h000, 1, 10'h1F5, 1, 0, 6,  1, 0, 0);
    vecs[28] = mk(1, 0, 10'h000, 0, 10'h000, 0, 0, 0,  0, 0, 0);
    vecs[29] = mk(0, 0, 10'h000, 0, 10'h001, 0, 0, 0,  0, 0, 0);

    // Directed cycle-by-cycle vectors
    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].rst; seed_load = vecs[i].sl; seed = vecs[i].sd; req = vecs[i].rq;
      tick();
      chk("ps",     i, 32'(dut.ps_q), 32'(vecs[i].e_ps));
      chk("busy",   i, 32'(busy0),    32'(vecs[i].e_busy));
      chk("pv",     i, 32'(pv0),      32'(vecs[i].e_pv));
      chk("piece",  i, 32'(piece0),   32'(vecs[i].e_piece));
      chk("busy1",  i, 32'(busy1),    32'(vecs[i].e1_busy));
      chk("pv1",    i, 32'(pv1),      32'(vecs[i].e1_pv));
      chk("piece1", i, 32'(piece1),   32'(vecs[i].e1_piece));
    end

    // req held high for 100 draws against a cycle model of both instances
    seed_load = 1'b0; seed = '0; req = 1'b1;
    m_ps = 10'h001;
    for (int j = 0; j < 2; j++) begin
      m_busy[j] = 1'b0; m_tries[j] = 0; m_pv[j] = 1'b0; m_piece[j] = 3'd0;
    end
    draws   = 0;
    last_pv = -10;
    for (int cyc = 0; cyc < 4000 && draws < 100; cyc++) begin
      mcand = m_ps[2:0];
      for (int j = 0; j < 2; j++) begin
        mt = (j == 0) ? 16 : 1;
        m_pv[j] = 1'b0;
        if (!m_busy[j]) begin
          if (req) begin m_busy[j] = 1'b1; m_tries[j] = 0; end
        end else if (mcand < 3'd7) begin
          m_piece[j] = mcand; m_pv[j] = 1'b1; m_busy[j] = 1'b0;
        end else if (m_tries[j] == mt - 1) begin
          m_piece[j] = 3'd0; m_pv[j] = 1'b1; m_busy[j] = 1'b0;
        end else begin
          m_tries[j] = m_tries[j] + 1;
        end
      end
      m_ps = {m_ps[8:0], ~(m_ps[9] ^ m_ps[6])};
      tick();
      chk("run_busy",   cyc, 32'(busy0),  32'(m_busy[0]));
      chk("run_pv",     cyc, 32'(pv0),    32'(m_pv[0]));
      chk("run_piece",  cyc, 32'(piece0), 32'(m_piece[0]));
      chk("run_busy1",  cyc, 32'(busy1),  32'(m_busy[1]));
      chk("run_pv1",    cyc, 32'(pv1),    32'(m_pv[1]));
      chk("run_piece1", cyc, 32'(piece1), 32'(m_piece[1]));
      if (pv0) begin
        chk("run_range", draws, 32'(piece0 < 3'd7), 32'd1);
        if (draws > 0) chk("run_gap", draws, 32'(cyc - last_pv >= 2), 32'd1);
        last_pv = cyc;
        draws++;
      end
    end
    chk("run_draws", 0, 32'(draws), 32'd100);

    // req still high: accepted in the pv cycle, then reset mid-DRAW
    tick();
    chk("accept_after_pv", 0, 32'(busy0), 32'd1);
    reset = 1'b1; req = 1'b0;
    tick();
    chk("rst_busy",  0, 32'(busy0),     32'd0);
    chk("rst_pv",    0, 32'(pv0),       32'd0);
    chk("rst_piece", 0, 32'(piece0),    32'd0);
    chk("rst_ps",    0, 32'(dut.ps_q),  32'd0);
    chk("rst_busy1", 0, 32'(busy1),     32'd0);
    chk("rst_pv1",   0, 32'(pv1),       32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_pv",   0, 32'(pv0),      32'd0);
    chk("post_rst_busy", 0, 32'(busy0),    32'd0);
    chk("post_rst_ps",   0, 32'(dut.ps_q), 32'h001);
`else
    // Bag mode: 14 back-to-back draws form two permutations of 0..6
    tick();
    tick();
    chk("bag_rst_mask", 0, 32'(dut.mask_q), 32'd0);
    chk("bag_rst_pv",   0, 32'(pv0),        32'd0);
    chk("bag_rst_busy", 0, 32'(busy0),      32'd0);
    reset = 1'b0; req = 1'b1;
    n0 = 0; n1 = 0;
    for (int cyc = 0; cyc < 3000 && (n0 < 14 || n1 < 14); cyc++) begin
      tick();
      if (pv0 && n0 < 14) begin
        p0[n0] = piece0; n0++;
        if (n0 == 7) chk("bag_mask0", 0, 32'(dut.mask_q), 32'd0);
      end
      if (pv1 && n1 < 14) begin
        p1[n1] = piece1; n1++;
        if (n1 == 7) chk("bag_mask1", 0, 32'(dut1.mask_q), 32'd0);
      end
    end
    chk("bag_draws0", 0, 32'(n0), 32'd14);
    chk("bag_draws1", 0, 32'(n1), 32'd14);
    for (int g = 0; g < 2; g++) begin
      for (int v = 0; v < 7; v++) begin
        cnt = 0;
        for (int k = 0; k < 7; k++) if (32'(p0[g*7+k]) == 32'(v)) cnt++;
        chk("bag_perm0", g*7+v, 32'(cnt), 32'd1);
        cnt = 0;
        for (int k = 0; k < 7; k++) if (32'(p1[g*7+k]) == 32'(v)) cnt++;
        chk("bag_perm1", g*7+v, 32'(cnt), 32'd1);
      end
    end
    req = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
